// File: rtl/circ_q_reader.sv
// circ_q_reader: consumer-side engine for the circular word queue.
// Issues single-cycle read strobes while the queue is non-empty and there is
// room downstream, captures each returned word one cycle later into a small
// circular output buffer, and re-presents words on a valid/ready stream.
module circ_q_reader #(
  parameter int WORD_SZ   = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             q_empty,
  output logic                             q_rd,
  input  logic [WORD_SZ-1:0]               q_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_SZ-1:0]               out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count,
  output logic [CNT_W-1:0]                 words_out
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [WORD_SZ-1:0] mem_q [BUF_DEPTH];
  logic [WORD_SZ-1:0] mem_d [BUF_DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   words_q, words_d;

  logic               pop;
  logic               capture;
  logic [CW:0]        occ;

  // Stream handshake, read-strobe gating and output presentation.
  always_comb begin
    pop       = (count_q != '0) & out_ready;
    capture   = inflight_q;
    // Occupancy this cycle once the in-flight word lands and any pop retires;
    // a pop implies count_q >= 1 so this never underflows.
    occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    q_rd      = en & ~q_empty & ~rst & (occ < (CW+1)'(BUF_DEPTH));
    out_valid = (count_q != '0);
    out_data  = (count_q != '0) ? mem_q[head_q] : '0;
    buf_count = count_q;
    words_out = words_q;
  end

  // Next-state for buffer storage, pointers, occupancy and handshake counter.
  always_comb begin
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = q_rd;
    words_d    = words_q;

    if (capture) begin
      mem_d[tail_q] = q_data;
      tail_d = (tail_q == PW'(BUF_DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d  = (head_q == PW'(BUF_DEPTH - 1)) ? '0 : head_q + 1'b1;
      words_d = words_q + 1'b1;
    end
    case ({capture, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      words_q    <= words_d;
    end
  end

endmodule

// File: tb/tb_circ_q_reader.sv
// Testbench for circ_q_reader: behavioural queue model feeding the reader,
// scoreboard of expected output words checked by an independent monitor,
// plus directed cycle-level checks of strobe timing, backpressure, enable
// and reset behaviour. A second instance with a 4-bit counter checks wrap.
module tb_circ_q_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        q_empty;
  logic        q_rd, q_rd4;
  logic [31:0] q_data = '0;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [31:0] out_data, out_data4;
  logic [1:0]  buf_count, buf_count4;
  logic [15:0] words_out;
  logic [3:0]  words_out4;

  int checks = 0;
  int errors = 0;
  int exp_words = 0;
  logic [31:0] exp_q [$];

  logic [31:0] qm [0:255];
  int rd_idx = 0;
  int wr_idx = 0;

  always #5 clk = ~clk;

  circ_q_reader dut (
    .clk(clk), .rst(rst), .en(en), .q_empty(q_empty), .q_rd(q_rd),
    .q_data(q_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .buf_count(buf_count), .words_out(words_out)
  );

  circ_q_reader #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .q_empty(q_empty), .q_rd(q_rd4),
    .q_data(q_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .buf_count(buf_count4), .words_out(words_out4)
  );

  // Queue model: registered empty flag, data valid the cycle after a read.
  assign q_empty = (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (q_rd && (rd_idx != wr_idx)) begin
      q_data <= qm[rd_idx[7:0]];
      rd_idx <= rd_idx + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input bit expect_out);
    qm[wr_idx[7:0]] = w;
    wr_idx++;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: scoreboard pops on each handshake, plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst) begin
      exp_words = 0;
    end else begin
      if (q_rd && q_empty) chk("rd_while_empty", 64'd1, 64'd0);
      if (buf_count > 2'd2) chk("buf_overflow", 64'(buf_count), 64'd2);
      if (q_rd && buf_count == 2'd2 && !(out_valid && out_ready))
        chk("rd_when_full", 64'd1, 64'd0);
      if (q_rd4 !== q_rd) chk("dut4_q_rd", 64'(q_rd4), 64'(q_rd));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(out_data), 64'hDEAD);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
        chk("words_out", 64'(words_out), 64'(exp_words[15:0]));
        chk("words_out4", 64'(words_out4), 64'(exp_words[3:0]));
        exp_words++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_buf_count", 64'(buf_count), 64'd0);
    chk("rst_words_out", 64'(words_out), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_q_rd", 64'(q_rd), 64'd0);

    // Test 1: four words, continuous ready; latency and throughput.
    tick();
    for (int i = 1; i <= 4; i++) push(32'hA5A50000 + 32'(i), 1'b1);
    en = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk("t1_c1_q_rd", 64'(q_rd), 64'd1); chk("t1_c1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("t1_c2_q_rd", 64'(q_rd), 64'd1); chk("t1_c2_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("t1_c3_q_rd", 64'(q_rd), 64'd1); chk("t1_c3_valid", 64'(out_valid), 64'd1);
    chk("t1_c3_data", 64'(out_data), 64'hA5A50001);
    @(negedge clk); chk("t1_c4_q_rd", 64'(q_rd), 64'd1); chk("t1_c4_valid", 64'(out_valid), 64'd1);
    @(negedge clk); chk("t1_c5_q_rd", 64'(q_rd), 64'd0); chk("t1_c5_valid", 64'(out_valid), 64'd1);
    @(negedge clk); chk("t1_c6_valid", 64'(out_valid), 64'd1); chk("t1_c6_data", 64'(out_data), 64'hA5A50004);
    @(negedge clk); chk("t1_c7_valid", 64'(out_valid), 64'd0); chk("t1_words", 64'(words_out), 64'd4);

    // Test 2: backpressure; only two reads while stalled.
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'hB0000000 + 32'(i), 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (q_rd) cnt++;
    end
    chk("t2_rd_pulses", 64'(cnt), 64'd2);
    chk("t2_buf_count", 64'(buf_count), 64'd2);
    chk("t2_head_stable", 64'(out_data), 64'hB0000000);
    @(negedge clk);
    chk("t2_head_stable2", 64'(out_data), 64'hB0000000);
    tick();
    out_ready = 1'b1;
    wait_drain("t2", 40);
    chk("t2_words", 64'(words_out), 64'd10);

    // Test 3: out_ready toggling with eight words.
    tick();
    for (int i = 0; i < 8; i++) push(32'(i), 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      tick();
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_drain("t3", 20);
    chk("t3_words", 64'(words_out), 64'd18);

    // Test 4: en dropped the cycle after the first read.
    tick();
    for (int i = 0; i < 3; i++) push(32'hC0000000 + 32'(i), 1'b1);
    en = 1'b1;
    @(negedge clk); chk("t4_first_rd", 64'(q_rd), 64'd1);
    tick();
    en = 1'b0;
    @(negedge clk); chk("t4_rd_drop", 64'(q_rd), 64'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (q_rd) cnt++;
    end
    chk("t4_no_rd_while_off", 64'(cnt), 64'd0);
    chk("t4_words_one", 64'(words_out), 64'd19);
    chk("t4_buf_empty", 64'(buf_count), 64'd0);
    tick();
    en = 1'b1;
    wait_drain("t4", 20);
    chk("t4_words", 64'(words_out), 64'd21);

    // Test 5: reset while a word is in flight and one is buffered.
    tick();
    out_ready = 1'b0;
    en = 1'b1;
    push(32'hDD000000, 1'b0);
    push(32'hDD000001, 1'b0);
    @(negedge clk); chk("t5_rd_a", 64'(q_rd), 64'd1);
    tick(); en = 1'b0;
    @(negedge clk); chk("t5_rd_b", 64'(q_rd), 64'd0);
    tick(); en = 1'b1;
    @(negedge clk); chk("t5_buf_one", 64'(buf_count), 64'd1); chk("t5_rd_c", 64'(q_rd), 64'd1);
    tick(); rst = 1'b1; en = 1'b0;
    @(negedge clk); chk("t5_rd_in_rst", 64'(q_rd), 64'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_buf_count", 64'(buf_count), 64'd0);
    chk("t5_words", 64'(words_out), 64'd0);
    @(negedge clk);
    chk("t5_not_captured", 64'(buf_count), 64'd0);

    // Test 6: seventeen words; 4-bit counter wraps to 1.
    tick();
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 17; i++) push(32'hE0000000 + 32'(i), 1'b1);
    wait_drain("t6", 60);
    chk("t6_words16", 64'(words_out), 64'd17);
    chk("t6_words4", 64'(words_out4), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
